// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if
//   Bundles the two requester handshakes and framebuffer RAM port B into one
//   interface. The arbiter uses the master view; requesters plus the RAM use
//   the slave view.
//   Requester N: rdN/wrN/xN/yN/wdataN in, ackN/rdataN/errN out (N = 0, 1).
//   RAM port B : x_b/y_b/read_b/write_b/in_b out, out_b/rdy_b in.
//   Status     : busy out.
interface fb_port_arbiter_if;
  logic       rd0, wr0, wdata0, ack0, rdata0, err0;
  logic [8:0] x0;
  logic [7:0] y0;
  logic       rd1, wr1, wdata1, ack1, rdata1, err1;
  logic [8:0] x1;
  logic [7:0] y1;
  logic [8:0] x_b;
  logic [7:0] y_b;
  logic       read_b, write_b, in_b, out_b, rdy_b;
  logic       busy;

  modport master (
    input  rd0, wr0, x0, y0, wdata0,
    output ack0, rdata0, err0,
    input  rd1, wr1, x1, y1, wdata1,
    output ack1, rdata1, err1,
    output x_b, y_b, read_b, write_b, in_b,
    input  out_b, rdy_b,
    output busy
  );

  modport slave (
    output rd0, wr0, x0, y0, wdata0,
    input  ack0, rdata0, err0,
    output rd1, wr1, x1, y1, wdata1,
    input  ack1, rdata1, err1,
    input  x_b, y_b, read_b, write_b, in_b,
    output out_b, rdy_b,
    input  busy
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Round-robin arbiter between two pixel requesters for framebuffer RAM
//   port B. Each grant becomes one single-cycle read/write strobe; the RAM
//   answers with rdy_b. Out-of-range coordinates are rejected without a RAM
//   access, and a RAM that never answers is abandoned after TIMEOUT cycles.
//   Ports: clk, rst (synchronous, active high), bus (master view of
//   fb_port_arbiter_if: requester handshakes, RAM port B, busy).
module fb_port_arbiter #(
  parameter int FB_W    = 320,
  parameter int FB_H    = 200,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  fb_port_arbiter_if.master  bus
);

  localparam int             CW       = $clog2(TIMEOUT);
  localparam logic [9:0]     FB_W_L   = 10'(FB_W);
  localparam logic [8:0]     FB_H_L   = 9'(FB_H);
  // WAIT ends when the incremented count would reach TIMEOUT-1.
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t          state_reg;
  logic            grant_reg, last_reg, is_write_reg;
  logic [8:0]      x_reg;
  logic [7:0]      y_reg;
  logic            wdata_reg;
  logic [CW-1:0]   cnt_reg;
  logic            read_b_reg, write_b_reg;
  logic [1:0]      ack_reg, rdata_reg, err_reg;

  logic [1:0]      rd_w, wr_w, wdata_w, pend_w, bad_w;
  logic [8:0]      x_w [2];
  logic [7:0]      y_w [2];
  logic            sel_w;

  assign rd_w    = {bus.rd1, bus.rd0};
  assign wr_w    = {bus.wr1, bus.wr0};
  assign wdata_w = {bus.wdata1, bus.wdata0};
  assign x_w[0]  = bus.x0;
  assign x_w[1]  = bus.x1;
  assign y_w[0]  = bus.y0;
  assign y_w[1]  = bus.y1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign pend_w[gi] = rd_w[gi] | wr_w[gi];
      assign bad_w[gi]  = ({1'b0, x_w[gi]} >= FB_W_L) || ({1'b0, y_w[gi]} >= FB_H_L);
    end
  endgenerate

  // On a tie the requester not served last wins; otherwise whoever is pending.
  assign sel_w = (pend_w == 2'b11) ? ~last_reg : pend_w[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= 1'b0;
      last_reg     <= 1'b1;
      is_write_reg <= 1'b0;
      x_reg        <= '0;
      y_reg        <= '0;
      wdata_reg    <= 1'b0;
      cnt_reg      <= '0;
      read_b_reg   <= 1'b0;
      write_b_reg  <= 1'b0;
      ack_reg      <= '0;
      rdata_reg    <= '0;
      err_reg      <= '0;
    end else begin
      read_b_reg  <= 1'b0;
      write_b_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          ack_reg <= '0;
          if (|pend_w) begin
            grant_reg    <= sel_w;
            last_reg     <= sel_w;
            is_write_reg <= wr_w[sel_w];
            x_reg        <= x_w[sel_w];
            y_reg        <= y_w[sel_w];
            wdata_reg    <= wdata_w[sel_w];
            if (bad_w[sel_w]) begin
              state_reg        <= ACK;
              ack_reg[sel_w]   <= 1'b1;
              err_reg[sel_w]   <= 1'b1;
              rdata_reg[sel_w] <= 1'b0;
            end else begin
              // Strobe is registered so it is high during the ISSUE cycle.
              state_reg   <= ISSUE;
              read_b_reg  <= ~wr_w[sel_w];
              write_b_reg <= wr_w[sel_w];
            end
          end
        end
        ISSUE: begin
          state_reg <= WAIT;
          cnt_reg   <= '0;
        end
        WAIT: begin
          if (bus.rdy_b) begin
            state_reg            <= ACK;
            ack_reg[grant_reg]   <= 1'b1;
            err_reg[grant_reg]   <= 1'b0;
            rdata_reg[grant_reg] <= is_write_reg ? 1'b0 : bus.out_b;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg            <= ACK;
            ack_reg[grant_reg]   <= 1'b1;
            err_reg[grant_reg]   <= 1'b1;
            rdata_reg[grant_reg] <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ACK: begin
          ack_reg   <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.x_b     = x_reg;
  assign bus.y_b     = y_reg;
  assign bus.in_b    = wdata_reg;
  assign bus.read_b  = read_b_reg;
  assign bus.write_b = write_b_reg;
  assign bus.ack0    = ack_reg[0];
  assign bus.ack1    = ack_reg[1];
  assign bus.rdata0  = rdata_reg[0];
  assign bus.rdata1  = rdata_reg[1];
  assign bus.err0    = err_reg[0];
  assign bus.err1    = err_reg[1];
  assign bus.busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter
//   Directed and randomized bench for fb_port_arbiter. A behavioural RAM
//   answers strobes after a programmable delay (or never). Expected grant
//   order, latency, error and read data come from a reference model built on
//   the arbitration rules and a record of completed writes.
module tb_fb_port_arbiter;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fb_port_arbiter_if bus ();

  fb_port_arbiter #(.FB_W(320), .FB_H(200), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // RAM model controls
  int   ram_delay = 1;
  bit   ram_mute  = 1'b0;
  bit   inject_rdy = 1'b0;
  bit   ram_mem [logic [16:0]];
  bit   ref_mem [logic [16:0]];

  // monitor results
  int         strobe_cnt = 0, strobe_long = 0, ack_cnt0 = 0, ack_cnt1 = 0, both_ack = 0;
  bit         prev_strobe = 1'b0;
  logic       st_rd, st_wr, st_in;
  logic [8:0] st_x;
  logic [7:0] st_y;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input bit rd, input bit wr,
                         input logic [8:0] x, input logic [7:0] y, input bit wd);
    if (r == 0) begin
      bus.rd0 = rd; bus.wr0 = wr; bus.x0 = x; bus.y0 = y; bus.wdata0 = wd;
    end else begin
      bus.rd1 = rd; bus.wr1 = wr; bus.x1 = x; bus.y1 = y; bus.wdata1 = wd;
    end
  endtask

  function automatic logic ack_of(input int r);
    return (r == 0) ? bus.ack0 : bus.ack1;
  endfunction
  function automatic logic err_of(input int r);
    return (r == 0) ? bus.err0 : bus.err1;
  endfunction
  function automatic logic rdata_of(input int r);
    return (r == 0) ? bus.rdata0 : bus.rdata1;
  endfunction
  function automatic bit ref_rd(input logic [8:0] x, input logic [7:0] y);
    return ref_mem.exists({x, y}) ? ref_mem[{x, y}] : 1'b0;
  endfunction

  // RAM: rdy_b pulses ram_delay cycles after the strobe cycle; reads return stored data.
  initial begin : ram_model
    bit         pend = 1'b0, p_rd = 1'b0;
    int         due = 0;
    logic [16:0] addr = '0;
    bus.rdy_b = 1'b0;
    bus.out_b = 1'b0;
    forever begin
      @(negedge clk);
      bus.rdy_b = 1'b0;
      bus.out_b = 1'b0;
      if (pend && cyc == due) begin
        bus.rdy_b = 1'b1;
        bus.out_b = p_rd ? (ram_mem.exists(addr) ? ram_mem[addr] : 1'b0) : 1'b0;
        pend = 1'b0;
      end
      if (inject_rdy) begin
        bus.rdy_b  = 1'b1;
        inject_rdy = 1'b0;
      end
      if (bus.read_b || bus.write_b) begin
        if (bus.write_b) ram_mem[{bus.x_b, bus.y_b}] = bus.in_b;
        if (!ram_mute) begin
          pend = 1'b1; due = cyc + ram_delay; p_rd = bus.read_b; addr = {bus.x_b, bus.y_b};
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.read_b || bus.write_b) begin
        strobe_cnt++;
        if (prev_strobe) strobe_long++;
        st_rd = bus.read_b; st_wr = bus.write_b; st_in = bus.in_b; st_x = bus.x_b; st_y = bus.y_b;
      end
      prev_strobe = bus.read_b || bus.write_b;
      if (bus.ack0) ack_cnt0++;
      if (bus.ack1) ack_cnt1++;
      if (bus.ack0 && bus.ack1) both_ack++;
    end
  end

  // One isolated access from an idle arbiter, checked against latency rules.
  task automatic access(input string tag, input int r, input bit rd, input bit wr,
                        input logic [8:0] x, input logic [7:0] y, input bit wd,
                        input int d, input bit mute);
    int c0, exp_cyc, s0, o0;
    bit bad, got;
    ram_delay = d;
    ram_mute  = mute;
    step();
    s0 = strobe_cnt;
    o0 = (r == 0) ? ack_cnt1 : ack_cnt0;
    set_req(r, rd, wr, x, y, wd);
    c0  = cyc;
    bad = (x >= 320) || (y >= 200);
    exp_cyc = bad ? c0 + 1 : (mute ? c0 + 1 + TIMEOUT : c0 + 2 + d);
    got = 1'b0;
    for (int w = 0; w < TIMEOUT + 16 && !got; w++) begin
      step();
      got = ack_of(r);
    end
    check($sformatf("%s.ack", tag), 32'(got), 32'd1);
    check($sformatf("%s.latency", tag), 32'(cyc - c0), 32'(exp_cyc - c0));
    check($sformatf("%s.err", tag), 32'(err_of(r)), 32'(bad || mute));
    if (bad || mute) check($sformatf("%s.rdata", tag), 32'(rdata_of(r)), 32'd0);
    else if (!wr)    check($sformatf("%s.rdata", tag), 32'(rdata_of(r)), 32'(ref_rd(x, y)));
    set_req(r, 1'b0, 1'b0, x, y, wd);
    check($sformatf("%s.strobes", tag), 32'(strobe_cnt - s0), bad ? 32'd0 : 32'd1);
    if (!bad) begin
      check($sformatf("%s.op", tag), {30'd0, st_wr, st_rd}, wr ? 32'd2 : 32'd1);
      check($sformatf("%s.addr", tag), {15'd0, st_x, st_y}, {15'd0, x, y});
      if (wr) check($sformatf("%s.in_b", tag), 32'(st_in), 32'(wd));
    end
    check($sformatf("%s.other_ack", tag), 32'((r == 0) ? ack_cnt1 : ack_cnt0), 32'(o0));
    $display("txn %s: req%0d rd=%0b wr=%0b (%0d,%0d) ack@+%0d err=%0b rdata=%0b",
             tag, r, rd, wr, x, y, cyc - c0, err_of(r), rdata_of(r));
    if (wr && !bad && !mute) ref_mem[{x, y}] = wd;
  endtask

  initial begin : stim
    int         a0, a1, last, exp_w, win;
    bit         act [2];
    bit         q_rd [2], q_wr [2], q_wd [2];
    logic [8:0] q_x [2];
    logic [7:0] q_y [2];
    bit         got, bad;

    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0);
    set_req(1, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0);
    step(); step();
    rst = 1'b0;
    step();
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.strobes", {30'd0, bus.read_b, bus.write_b}, 32'd0);
    check("reset.acks", {28'd0, bus.ack0, bus.ack1, bus.err0, bus.err1}, 32'd0);
    check("reset.rdata", {30'd0, bus.rdata0, bus.rdata1}, 32'd0);
    check("reset.port", {15'd0, bus.x_b, bus.y_b}, 32'd0);
    check("reset.in_b", 32'(bus.in_b), 32'd0);

    access("write0",  0, 1'b0, 1'b1, 9'd10, 8'd20, 1'b1, 2, 1'b0);
    access("read1",   1, 1'b1, 1'b0, 9'd10, 8'd20, 1'b0, 1, 1'b0);
    access("range_x", 0, 1'b0, 1'b1, 9'd320, 8'd5, 1'b1, 1, 1'b0);
    access("range_y", 0, 1'b0, 1'b1, 9'd5, 8'd200, 1'b1, 1, 1'b0);
    access("edge_ok", 0, 1'b0, 1'b1, 9'd319, 8'd199, 1'b1, 1, 1'b0);
    access("timeout", 0, 1'b1, 1'b0, 9'd30, 8'd40, 1'b0, 1, 1'b1);

    // Late rdy_b after the timeout must be ignored.
    a0 = ack_cnt0; a1 = ack_cnt1;
    step(); step(); step();
    inject_rdy = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("late_rdy.acks", 32'(ack_cnt0 + ack_cnt1), 32'(a0 + a1));
    check("late_rdy.busy", 32'(bus.busy), 32'd0);
    check("err_hold", 32'(bus.err0), 32'd1);

    // Reset while the arbiter waits on a silent RAM.
    ram_mute = 1'b1;
    step();
    set_req(0, 1'b1, 1'b0, 9'd50, 8'd60, 1'b0);
    step(); step(); step();
    check("wait.busy", 32'(bus.busy), 32'd1);
    a0 = ack_cnt0;
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0);
    step();
    rst = 1'b0;
    check("rst_wait.busy", 32'(bus.busy), 32'd0);
    check("rst_wait.outs", {22'd0, bus.read_b, bus.write_b, bus.ack0, bus.ack1,
                            bus.err0, bus.err1, bus.rdata0, bus.rdata1, bus.in_b, 1'b0}, 32'd0);
    check("rst_wait.port", {15'd0, bus.x_b, bus.y_b}, 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("rst_wait.no_ack", 32'(ack_cnt0), 32'(a0));
    access("rdwr0", 0, 1'b1, 1'b1, 9'd7, 8'd8, 1'b1, 1, 1'b0);

    // Contention: both requesters, round-robin order from the model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    ram_mute = 1'b0;
    last = 1;
    act[0] = 1'b0; act[1] = 1'b0;
    for (int g = 0; g < 24; g++) begin
      step();
      for (int r = 0; r < 2; r++) begin
        if (!act[r] && (g < 8 || $urandom_range(0, 3) != 0 || (r == 1 && !act[0]))) begin
          int op;
          op = (g == 0) ? ((r == 0) ? 0 : 1) : int'($urandom_range(0, 2));
          q_rd[r] = (op != 1);
          q_wr[r] = (op != 0);
          q_wd[r] = 1'($urandom_range(0, 1));
          q_x[r]  = ($urandom_range(0, 7) == 0) ? 9'(320 + $urandom_range(0, 40)) : 9'($urandom_range(0, 15));
          q_y[r]  = 8'($urandom_range(0, 7));
          act[r]  = 1'b1;
          set_req(r, q_rd[r], q_wr[r], q_x[r], q_y[r], q_wd[r]);
        end
      end
      exp_w = (act[0] && act[1]) ? 1 - last : (act[1] ? 1 : 0);
      last  = exp_w;
      ram_delay = int'($urandom_range(1, 3));
      got = 1'b0; win = -1;
      for (int w = 0; w < 20 && !got; w++) begin
        step();
        if (bus.ack0) begin got = 1'b1; win = 0; end
        else if (bus.ack1) begin got = 1'b1; win = 1; end
      end
      check($sformatf("rr%0d.ack", g), 32'(got), 32'd1);
      if (!got) break;
      check($sformatf("rr%0d.winner", g), 32'(win), 32'(exp_w));
      bad = (q_x[win] >= 320) || (q_y[win] >= 200);
      check($sformatf("rr%0d.err", g), 32'(err_of(win)), 32'(bad));
      if (bad) check($sformatf("rr%0d.rdata", g), 32'(rdata_of(win)), 32'd0);
      else if (!q_wr[win]) check($sformatf("rr%0d.rdata", g), 32'(rdata_of(win)), 32'(ref_rd(q_x[win], q_y[win])));
      $display("txn rr%0d: req%0d rd=%0b wr=%0b (%0d,%0d) err=%0b rdata=%0b",
               g, win, q_rd[win], q_wr[win], q_x[win], q_y[win], err_of(win), rdata_of(win));
      if (q_wr[win] && !bad) ref_mem[{q_x[win], q_y[win]}] = q_wd[win];
      set_req(win, 1'b0, 1'b0, q_x[win], q_y[win], q_wd[win]);
      act[win] = 1'b0;
    end
    set_req(0, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0);
    set_req(1, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0);
    for (int i = 0; i < 8; i++) step();
    check("strobe_width", 32'(strobe_long), 32'd0);
    check("dual_ack", 32'(both_ack), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Two-requester round-robin arbiter for framebuffer RAM port B (the `mclk`-side port carrying x_b/y_b/read_b/write_b/in_b/out_b/rdy_b). It sits between the EPP-facing host register block (requester 0) and a drawing engine (requester 1). It serialises their pixel accesses and drives port B with single-cycle strobes. It also rejects out-of-range coordinates and recovers from a RAM that never answers.

## Interface
Parameters:
- FB_W, 320, visible width in pixels; requests with x ≥ FB_W are rejected.
- FB_H, 200, visible height in lines; requests with y ≥ FB_H are rejected.
- TIMEOUT, 64, maximum WAIT cycles before the access is abandoned (≥ 2).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (mclk domain).
- rst  in  1  synchronous active-high reset.
- rd0, wr0  in  1 each  requester 0 read/write request level.
- x0  in  9  requester 0 pixel x.
- y0  in  8  requester 0 pixel y.
- wdata0  in  1  requester 0 write pixel.
- ack0  out  1  requester 0 completion pulse.
- rdata0  out  1  requester 0 read pixel, valid with ack0.
- err0  out  1  requester 0 error flag, valid with ack0.
- rd1, wr1, x1, y1, wdata1, ack1, rdata1, err1  same as above for requester 1.
- x_b  out  9  RAM port B x.
- y_b  out  8  RAM port B y.
- read_b  out  1  RAM read strobe.
- write_b  out  1  RAM write strobe.
- in_b  out  1  RAM write data.
- out_b  in  1  RAM read data, valid with rdy_b.
- rdy_b  in  1  RAM completion pulse.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Requester protocol:
  - Assert rdN or wrN as a level. Hold xN, yN and wdataN stable until ackN.
  - Drop the request on the clock edge that samples ackN = 1.
  - If rdN and wrN are both high, the request is a write.
- FSM has four states: IDLE, ISSUE, WAIT, ACK.
- IDLE: pick a pending requester.
  - If both are pending, grant the one not served last. A last-grant pointer is updated at every grant; reset makes requester 0 win the first tie.
  - Latch the grant index, the operation, x, y and wdata.
  - If x ≥ FB_W or y ≥ FB_H, go straight to ACK with err = 1 and rdata = 0. No RAM access occurs.
  - Otherwise go to ISSUE.
- ISSUE: drive read_b or write_b high for exactly this one cycle, with x_b/y_b/in_b from the latch. Go to WAIT and clear the timeout counter.
- WAIT: x_b/y_b/in_b hold their values; both strobes are low.
  - On rdy_b = 1: capture out_b (reads only) and go to ACK with err = 0.
  - When the counter reaches TIMEOUT−1 without rdy_b: go to ACK with err = 1 and rdata = 0.
- ACK: for the granted requester only, drive ackN = 1 with rdataN and errN. Next state is IDLE.
- rdy_b is ignored in IDLE, ISSUE and ACK, so a late rdy_b after a timeout has no effect.
- Requests from the non-granted requester stay pending and are never lost.

## Timing
- Reset values: state IDLE; pointer favours requester 0; all strobes, acks, errs, rdatas and busy are 0; x_b = 0, y_b = 0, in_b = 0.
- Reset mid-transaction aborts it with no ack issued; the RAM may still complete the access.
- rdataN and errN are registered and hold their value until the next ackN to the same requester.
- Latency, with a request first seen in IDLE at cycle n:
  - read_b/write_b high at n+1.
  - With rdy_b at cycle k ≥ n+2, ackN is high at k+1.
  - Minimum request-to-ack is 3 cycles.
  - A rejected request acks at n+1.
- Timeout: if no rdy_b arrives, ack comes at n+1+TIMEOUT.
- Back-to-back: the next grant is decided in the IDLE cycle after ACK, so per-access throughput is 4 cycles minimum.
- Requests asserted during ISSUE, WAIT or ACK are sampled only in IDLE.

## Test plan
- Single access: requester 0 writes (10,20)=1 while the RAM model answers rdy_b 2 cycles after write_b. Required: write_b high for 1 cycle with x_b=10, y_b=20, in_b=1; ack0 follows; err0=0; no ack1.
- Read-back: requester 1 reads (10,20) with out_b=1. Required: ack1 with rdata1=1, err1=0, and ack at request+3 cycles with a 1-cycle RAM delay.
- Contention: rd0 and wr1 asserted in the same cycle after reset. Required: requester 0 is served first, then requester 1, then requester 0 again if still pending; the alternation holds over 8 grants.
- Range check: wr0 at (320,5), then at (5,200). Required: ack0 with err0=1 one cycle after the request; read_b and write_b never assert.
- Timeout: the RAM model never answers. Required: ack0 with err0=1, rdata0=0 at n+1+64. A rdy_b injected 3 cycles later causes no spurious ack.
- Reset during WAIT, plus simultaneous rd0 and wr0. Required: rst clears busy and all outputs to 0 with no ack issued; after rst, a request with rd0 and wr0 both high produces write_b, not read_b.
